// File: rtl/fp_pkg.sv
// Shared floating-point parameters and the normalise/round controller states.
package fp_pkg;

  localparam int SIG_BITS = 23;
  localparam int EXP_BITS = 8;
  localparam int EXP_MAX  = (1 << EXP_BITS) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rne_round.sv
// Combinational round-to-nearest-even of a stored fraction given its guard/round/sticky bits.
module rne_round #(
  parameter int SIG_BITS = fp_pkg::SIG_BITS
) (
  input  logic [SIG_BITS-1:0] frac_i,
  input  logic [2:0]          grs_i,
  output logic [SIG_BITS-1:0] frac_o,
  output logic                carry_o,
  output logic                inexact_o
);

  logic                inc;
  logic [SIG_BITS:0]   sum;

  // Ties (G=1, R=S=0) round up only when the fraction LSB is odd.
  assign inc       = grs_i[2] & (grs_i[1] | grs_i[0] | frac_i[0]);
  assign sum       = {1'b0, frac_i} + {{SIG_BITS{1'b0}}, inc};
  assign frac_o    = sum[SIG_BITS-1:0];
  assign carry_o   = sum[SIG_BITS];
  assign inexact_o = |grs_i;

endmodule

// File: rtl/norm_round.sv
// Multi-cycle normaliser and RNE rounder turning a raw adder significand into a packed IEEE-754 result.
module norm_round #(
  parameter int SIG_BITS = fp_pkg::SIG_BITS,
  parameter int EXP_BITS = fp_pkg::EXP_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [EXP_BITS-1:0]          in_exp,
  input  logic [SIG_BITS+4:0]          in_sig,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_BITS+SIG_BITS:0]   out_result,
  output logic                         out_overflow,
  output logic                         out_underflow,
  output logic                         out_inexact
);

  import fp_pkg::state_t;
  import fp_pkg::IDLE;
  import fp_pkg::NORM;
  import fp_pkg::ROUND;
  import fp_pkg::DONE;

  localparam int SW = SIG_BITS + 5;
  localparam int EW = EXP_BITS + 2;
  localparam int CB = SIG_BITS + 4;
  localparam int HB = SIG_BITS + 3;
  localparam int RW = EXP_BITS + SIG_BITS + 1;
  localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_BITS) - 1);
  localparam logic [EW-1:0] EXP_ONE = EW'(1);

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EW-1:0]     exp_q, exp_d;
  logic [SW-1:0]     sig_q, sig_d;
  logic [RW-1:0]     res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              inx_q, inx_d;

  logic [SIG_BITS-1:0] rnd_frac;
  logic                rnd_carry;
  logic                rnd_inexact;
  logic [EW-1:0]       exp_fld;

  rne_round #(.SIG_BITS(SIG_BITS)) u_rne (
    .frac_i    (sig_q[SIG_BITS+2:3]),
    .grs_i     (sig_q[2:0]),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  // A rounding carry on a normal bumps the exponent; on a denormal it creates the hidden bit (field 1).
  always_comb begin
    exp_fld = '0;
    if (sig_q[HB]) begin
      exp_fld = exp_q + EW'(rnd_carry);
    end else if (rnd_carry) begin
      exp_fld = exp_q;
    end
  end

  assign in_ready      = (state_q == IDLE) & ~reset;
  assign out_valid     = (state_q == DONE);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_sign;
          sig_d   = in_sig;
          exp_d   = (in_exp == '0) ? EXP_ONE : EW'(in_exp);
          state_d = NORM;
        end
      end
      NORM: begin
        if (sig_q == '0) begin
          state_d = ROUND;
        end else if (sig_q[CB]) begin
          sig_d = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + EXP_ONE;
        end else if (sig_q[HB]) begin
          state_d = ROUND;
        end else if (exp_q == EXP_ONE) begin
          state_d = ROUND;
        end else begin
          sig_d = {sig_q[SW-2:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (sig_q == '0) begin
          res_d = {sign_q, {(RW-1){1'b0}}};
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inx_d = 1'b0;
        end else if (exp_fld >= EXP_INF) begin
          res_d = {sign_q, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
          ovf_d = 1'b1;
          unf_d = 1'b0;
          inx_d = 1'b1;
        end else begin
          res_d = {sign_q, exp_fld[EXP_BITS-1:0], rnd_frac};
          ovf_d = 1'b0;
          unf_d = rnd_inexact & (exp_fld == '0);
          inx_d = rnd_inexact;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

endmodule
